// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, fault codes, FSM states.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      FC_OK    = 2'b00,
      FC_ALIGN = 2'b01,
      FC_RANGE = 2'b10
   } fcode_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned LANES   = DATA_W / 8;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store mask/replication with alignment check, and load
// extraction with sign/zero extension. Purely combinational.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [1:0]        st_size,
   input  logic [1:0]        st_lo,
   input  logic [DATA_W-1:0] st_wdata,
   output logic [LANES-1:0]  wmask_c,
   output logic [DATA_W-1:0] wlanes_c,
   output logic              align_err_c,
   input  logic [1:0]        ld_size,
   input  logic [1:0]        ld_lo,
   input  logic              ld_signed,
   input  logic [DATA_W-1:0] ld_word,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] shifted_c;

   // Store side: lane enables, replicated data and alignment.
   always_comb begin
      wmask_c     = '0;
      wlanes_c    = st_wdata;
      align_err_c = 1'b0;
      case (st_size)
         SZ_BYTE: begin
            wmask_c  = 4'b0001 << st_lo;
            wlanes_c = {4{st_wdata[7:0]}};
         end
         SZ_HALF: begin
            wmask_c     = st_lo[1] ? 4'b1100 : 4'b0011;
            wlanes_c    = {2{st_wdata[15:0]}};
            align_err_c = st_lo[0];
         end
         SZ_WORD: begin
            wmask_c     = 4'b1111;
            align_err_c = |st_lo;
         end
         default: align_err_c = 1'b1;
      endcase
   end

   // Load side: move the addressed lanes to bit 0, then extend.
   always_comb begin
      shifted_c = ld_word >> {ld_lo, 3'b000};
      rdata_c   = ld_word;
      case (ld_size)
         SZ_BYTE: rdata_c = {{24{ld_signed & shifted_c[7]}}, shifted_c[7:0]};
         SZ_HALF: rdata_c = {{16{ld_signed & shifted_c[15]}}, shifted_c[15:0]};
         default: rdata_c = ld_word;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory behind a valid/ready port with a one-cycle response.
// Optional post-reset zero sweep enabled by defining DMEM_CLEAR_ON_RESET_EN.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 12,
   parameter logic [31:0] BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [1:0]  rsp_code,
   output logic        busy
);

   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned HI_LSB = ADDR_W + 2;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept_c;
   logic [ADDR_W-1:0] idx_c;
   logic              range_ok_c;
   logic              align_err_c;
   logic              fault_c;
   fcode_e            code_c;
   logic [LANES-1:0]  wmask_c;
   logic [DATA_W-1:0] wlanes_c;
   logic [DATA_W-1:0] rdata_c;

   logic [DATA_W-1:0] rd_word;
   logic              ld_q;
   logic [1:0]        ld_size;
   logic [1:0]        ld_lo;
   logic              ld_signed;

   // A request arriving while reset is asserted is never taken.
   assign accept_c   = req_valid && req_ready && !reset;
   assign idx_c      = req_addr[HI_LSB-1:2];
   assign range_ok_c = (req_addr[31:HI_LSB] == BASE[31:HI_LSB]);

   // Misalignment outranks range.
   always_comb begin
      code_c = FC_OK;
      if (align_err_c)      code_c = FC_ALIGN;
      else if (!range_ok_c) code_c = FC_RANGE;
   end

   assign fault_c = (code_c != FC_OK);

   dmem_lane_fmt u_fmt (
      .st_size     (req_size),
      .st_lo       (req_addr[1:0]),
      .st_wdata    (req_wdata),
      .wmask_c     (wmask_c),
      .wlanes_c    (wlanes_c),
      .align_err_c (align_err_c),
      .ld_size     (ld_size),
      .ld_lo       (ld_lo),
      .ld_signed   (ld_signed),
      .ld_word     (rd_word),
      .rdata_c     (rdata_c)
   );

`ifdef DMEM_CLEAR_ON_RESET_EN
   state_e            state;
   logic [ADDR_W-1:0] cnt;

   // Sweep FSM: zero every word once after reset, then serve requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_CLEAR;
         cnt       <= '0;
         req_ready <= 1'b0;
         busy      <= 1'b1;
      end else if (state == ST_CLEAR) begin
         cnt <= cnt + ADDR_W'(1);
         if (cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
         end
      end
   end
`else
   assign req_ready = 1'b1;
   assign busy      = 1'b0;
`endif

   // Word array: sweep writes or lane-masked stores; faulting stores write nothing.
   always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (!reset && state == ST_CLEAR) begin
         mem[cnt] <= '0;
      end else
`endif
      if (accept_c && req_we && !fault_c) begin
         for (int k = 0; k < LANES; k++) begin
            if (wmask_c[k]) mem[idx_c][8*k +: 8] <= wlanes_c[8*k +: 8];
         end
      end
   end

   // Synchronous read; a store on the previous edge is already visible here.
   always_ff @(posedge clk) begin
      if (accept_c && !req_we) rd_word <= mem[idx_c];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_fault <= 1'b0;
         rsp_code  <= FC_OK;
         ld_q      <= 1'b0;
         ld_size   <= SZ_BYTE;
         ld_lo     <= 2'b00;
         ld_signed <= 1'b0;
      end else begin
         rsp_valid <= accept_c;
         rsp_fault <= accept_c && fault_c;
         rsp_code  <= accept_c ? code_c : FC_OK;
         ld_q      <= accept_c && !req_we && !fault_c;
         if (accept_c) begin
            ld_size   <= req_size;
            ld_lo     <= req_addr[1:0];
            ld_signed <= req_signed;
         end
      end
   end

   // Stores, faults and idle cycles present zero data.
   assign rsp_rdata = ld_q ? rdata_c : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (ADDR_W=4, BASE=0); covers both
// builds of DMEM_CLEAR_ON_RESET_EN.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [1:0]  rsp_code;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_W(4), .BASE(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .rsp_code   (rsp_code),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] rdata,
                          input logic fault, input logic [1:0] code);
      chk({tag, ".valid"}, 32'(rsp_valid), 32'(1'b1));
      chk({tag, ".rdata"}, rsp_rdata, rdata);
      chk({tag, ".fault"}, 32'(rsp_fault), 32'(fault));
      chk({tag, ".code"},  32'(rsp_code),  32'(code));
   endtask

   // Single request: drive at a negedge, check the response one cycle later.
   task automatic xact(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic fault, input logic [1:0] code);
      drive(we, size, sgn, addr, wdata);
      @(negedge clk);
      req_valid = 1'b0;
      chk_rsp(tag, rdata, fault, code);
   endtask

   // Counts cycles until busy drops, bounded.
   task automatic wait_sweep(input string tag, input int exp_cycles);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".cycles"}, 32'(n), 32'(exp_cycles));
      chk({tag, ".ready"}, 32'(req_ready), 32'(1'b1));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.rsp_rdata", rsp_rdata, 32'd0);
      chk("rst.rsp_fault", 32'(rsp_fault), 32'd0);
      chk("rst.rsp_code",  32'(rsp_code), 32'd0);
`ifdef DMEM_CLEAR_ON_RESET_EN
      chk("rst.busy",  32'(busy), 32'd1);
      chk("rst.ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      wait_sweep("sweep0", 16);
      xact("ld_3c", 1'b0, 2'b10, 1'b0, 32'h3C, '0, 32'h0, 1'b0, 2'b00);
`else
      chk("rst.busy",  32'(busy), 32'd0);
      chk("rst.ready", 32'(req_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);
`endif
      chk("idle.rsp_valid", 32'(rsp_valid), 32'd0);

      xact("st_w0", 1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0, 2'b00);

      // Store then back-to-back loads of the same word.
      drive(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678);
      @(negedge clk);
      chk_rsp("st_w8", 32'h0, 1'b0, 2'b00);
      drive(1'b0, 2'b00, 1'b1, 32'hB, '0);
      @(negedge clk);
      chk_rsp("ld_bs_b", 32'h0000_0012, 1'b0, 2'b00);
      drive(1'b0, 2'b00, 1'b0, 32'hA, '0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_rsp("ld_bu_a", 32'h0000_0034, 1'b0, 2'b00);

      xact("st_b9",   1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0080, 32'h0, 1'b0, 2'b00);
      xact("ld_hs_8", 1'b0, 2'b01, 1'b1, 32'h8, '0, 32'hFFFF_8078, 1'b0, 2'b00);
      xact("ld_w_8",  1'b0, 2'b10, 1'b0, 32'h8, '0, 32'h1234_8078, 1'b0, 2'b00);
      xact("ld_hu_a", 1'b0, 2'b01, 1'b0, 32'hA, '0, 32'h0000_1234, 1'b0, 2'b00);
      xact("ld_bs_9", 1'b0, 2'b00, 1'b1, 32'h9, '0, 32'hFFFF_FF80, 1'b0, 2'b00);

      xact("st_h6",   1'b1, 2'b01, 1'b0, 32'h6, 32'h5555_BEEF, 32'h0, 1'b0, 2'b00);
      xact("ld_hu_6", 1'b0, 2'b01, 1'b0, 32'h6, '0, 32'h0000_BEEF, 1'b0, 2'b00);
      xact("ld_hs_6", 1'b0, 2'b01, 1'b1, 32'h6, '0, 32'hFFFF_BEEF, 1'b0, 2'b00);

      // Alignment and illegal size.
      xact("ld_w_6",   1'b0, 2'b10, 1'b0, 32'h6, '0, 32'h0, 1'b1, 2'b01);
      xact("st_h9",    1'b1, 2'b01, 1'b0, 32'h9, 32'h0000_AAAA, 32'h0, 1'b1, 2'b01);
      xact("ld_w_8b",  1'b0, 2'b10, 1'b0, 32'h8, '0, 32'h1234_8078, 1'b0, 2'b00);
      xact("ld_ill",   1'b0, 2'b11, 1'b0, 32'h0, '0, 32'h0, 1'b1, 2'b01);

      // Range: 0x40 aliases word 0 if not rejected.
      xact("st_w40",   1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b10);
      xact("ld_w_0",   1'b0, 2'b10, 1'b0, 32'h0, '0, 32'hCAFE_F00D, 1'b0, 2'b00);
      xact("ld_w_41",  1'b0, 2'b10, 1'b0, 32'h41, '0, 32'h0, 1'b1, 2'b01);
      xact("ld_b_top", 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, '0, 32'h0, 1'b1, 2'b10);

      // Reset during a response with a request still presented.
      drive(1'b0, 2'b10, 1'b0, 32'h8, '0);
      @(negedge clk);
      chk_rsp("ld_pre_rst", 32'h1234_8078, 1'b0, 2'b00);
      reset = 1'b1;
      @(negedge clk);
      chk("rstrsp.valid", 32'(rsp_valid), 32'd0);
      chk("rstrsp.rdata", rsp_rdata, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      repeat (5) @(negedge clk);
      chk("midsweep.busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midsweep.rsp_valid", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      wait_sweep("sweep1", 16);
      xact("ld_w_8_post", 1'b0, 2'b10, 1'b0, 32'h8, '0, 32'h0, 1'b0, 2'b00);
`else
      @(negedge clk);
      chk("post_rst.ready", 32'(req_ready), 32'd1);
      xact("ld_w_8_post", 1'b0, 2'b10, 1'b0, 32'h8, '0, 32'h1234_8078, 1'b0, 2'b00);
`endif
      @(negedge clk);
      chk("end.rsp_valid", 32'(rsp_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
